ascon_perm_wserial: RTL and testbench

Width-scalable successor to the single-bit Ascon round engine. It holds the full 320-bit Ascon state (lanes x0..x4, 64 bits each) and applies a run-time-selectable number of rounds (p12 / p8 / p6 or any 0..12). Each round is a W-bit-sliced substitution pass, with the constant folded in, followed by a single-cycle parallel linear diffusion. State enters and leaves over valid/ready streaming ports, W bits per lane per beat. It sits between the mode controller (init / associated data / finalisation) and the rate/capacity absorb logic.

---
 rtl/ascon_pkg.sv | 22 ++
 rtl/ascon_sbox_slice.sv | 43 ++++
 rtl/ascon_perm_wserial.sv | 122 ++++++++++++
 tb/tb_ascon_perm_wserial.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/ascon_pkg.sv
// rtl/ascon_pkg.sv - shared types, lane rotation amounts and round constant for the Ascon permutation
package ascon_pkg;

  localparam int LANE_W = 64;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SBOX,
    ST_LIN,
    ST_UNLOAD
  } state_t;

  // Linear layer rotate-right amounts, lane i uses ROT_A[i] and ROT_B[i]
  localparam int ROT_A [5] = '{19, 61, 1, 10, 7};
  localparam int ROT_B [5] = '{28, 39, 6, 17, 41};

  function automatic logic [7:0] rc(input logic [3:0] j);
    return {4'd15 - j, j};
  endfunction

endpackage

// File: rtl/ascon_sbox_slice.sv
// rtl/ascon_sbox_slice.sv - W parallel 5-bit Ascon S-boxes, bit-sliced over five W-bit buses
module ascon_sbox_slice #(
  parameter int W = 1
) (
  input  logic [W-1:0] x0,
  input  logic [W-1:0] x1,
  input  logic [W-1:0] x2,
  input  logic [W-1:0] x3,
  input  logic [W-1:0] x4,
  output logic [W-1:0] y0,
  output logic [W-1:0] y1,
  output logic [W-1:0] y2,
  output logic [W-1:0] y3,
  output logic [W-1:0] y4
);

  logic [W-1:0] a0, a2, a4;
  logic [W-1:0] t0, t1, t2, t3, t4;
  logic [W-1:0] b0, b1, b2, b3, b4;

  always_comb begin
    a0 = x0 ^ x4;
    a4 = x4 ^ x3;
    a2 = x2 ^ x1;
    // chi-like nonlinear step on the pre-mixed columns
    t0 = ~a0 & x1;
    t1 = ~x1 & a2;
    t2 = ~a2 & x3;
    t3 = ~x3 & a4;
    t4 = ~a4 & a0;
    b0 = a0 ^ t1;
    b1 = x1 ^ t2;
    b2 = a2 ^ t3;
    b3 = x3 ^ t4;
    b4 = a4 ^ t0;
    y0 = b0 ^ b4;
    y1 = b1 ^ b0;
    y2 = ~b2;
    y3 = b3 ^ b2;
    y4 = b4;
  end

endmodule

// File: rtl/ascon_perm_wserial.sv
// rtl/ascon_perm_wserial.sv - W-bit-sliced Ascon permutation with streaming load/unload
module ascon_perm_wserial
  import ascon_pkg::*;
#(
  parameter int W = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       rounds,
  input  logic [5*W-1:0]   in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [5*W-1:0]   out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy
);

  localparam int B  = LANE_W / W;
  localparam int BW = (B > 1) ? $clog2(B) : 1;

  if (W != 1 && W != 2 && W != 4 && W != 8 && W != 16 && W != 32 && W != 64) begin : g_bad_w
    $error("ascon_perm_wserial: W must be 1, 2, 4, 8, 16, 32 or 64");
  end

  state_t              state;
  logic [LANE_W-1:0]   x [5];
  logic [BW-1:0]       beat;
  logic [3:0]          rnd;
  logic [3:0]          rounds_eff;

  logic                last_beat;
  logic [W-1:0]        top [5];
  logic [W-1:0]        s [5];
  logic [7:0]          rc_cur;
  logic [LANE_W-1:0]   rc_lane;
  logic [W-1:0]        rc_slice;

  function automatic logic [LANE_W-1:0] rotr(input logic [LANE_W-1:0] v, input int r);
    return (v >> r) | (v << (LANE_W - r));
  endfunction

  assign last_beat = (beat == BW'(B - 1));

  always_comb begin
    for (int i = 0; i < 5; i++) top[i] = x[i][LANE_W-1 -: W];
    // j = (12 - rounds_eff) + rnd; the lanes rotate, so the slice at the top is beat*W bits in
    rc_cur   = rc(4'(4'd12 - rounds_eff + rnd));
    rc_lane  = {56'd0, rc_cur} << (W * int'(beat));
    rc_slice = W'(rc_lane >> (LANE_W - W));
  end

  ascon_sbox_slice #(.W(W)) u_sbox (
    .x0(top[0]),
    .x1(top[1]),
    .x2(top[2] ^ rc_slice),
    .x3(top[3]),
    .x4(top[4]),
    .y0(s[0]),
    .y1(s[1]),
    .y2(s[2]),
    .y3(s[3]),
    .y4(s[4])
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      beat       <= '0;
      rnd        <= '0;
      rounds_eff <= '0;
      for (int i = 0; i < 5; i++) x[i] <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            rounds_eff <= (rounds > 4'd12) ? 4'd12 : rounds;
            beat       <= '0;
            rnd        <= '0;
            state      <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (in_valid) begin
            for (int i = 0; i < 5; i++) x[i] <= LANE_W'({x[i], in_data[(4-i)*W +: W]});
            beat <= last_beat ? '0 : beat + 1'b1;
            if (last_beat) state <= (rounds_eff == 4'd0) ? ST_UNLOAD : ST_SBOX;
          end
        end
        ST_SBOX: begin
          for (int i = 0; i < 5; i++) x[i] <= LANE_W'({x[i], s[i]});
          beat <= last_beat ? '0 : beat + 1'b1;
          if (last_beat) state <= ST_LIN;
        end
        ST_LIN: begin
          for (int i = 0; i < 5; i++) x[i] <= x[i] ^ rotr(x[i], ROT_A[i]) ^ rotr(x[i], ROT_B[i]);
          rnd   <= rnd + 4'd1;
          state <= ((rnd + 4'd1) == rounds_eff) ? ST_UNLOAD : ST_SBOX;
        end
        ST_UNLOAD: begin
          if (out_ready) begin
            for (int i = 0; i < 5; i++) x[i] <= LANE_W'({x[i], {W{1'b0}}});
            beat <= last_beat ? '0 : beat + 1'b1;
            if (last_beat) state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    out_data = '0;
    for (int i = 0; i < 5; i++) out_data[(4-i)*W +: W] = top[i];
  end

  assign in_ready  = (state == ST_LOAD);
  assign out_valid = (state == ST_UNLOAD);
  assign busy      = (state != ST_IDLE);

endmodule

// File: tb/tb_ascon_perm_wserial.sv
// tb/tb_ascon_perm_wserial.sv - scoreboard bench for ascon_perm_wserial against a table-driven Ascon model
module tb_ascon_perm_wserial;

  localparam int W = 4;
  localparam int B = 64 / W;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           start = 1'b0;
  logic [3:0]     rounds = '0;
  logic [5*W-1:0] in_data = '0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [5*W-1:0] out_data;
  logic           out_valid;
  logic           out_ready = 1'b1;
  logic           busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit bp_out = 1'b0;
  logic [319:0] exp_q [$];

  localparam logic [4:0] SBOX [32] = '{
    5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
    5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
    5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
    5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17
  };

  ascon_perm_wserial #(.W(W)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .rounds(rounds),
    .in_data(in_data),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .out_data(out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] ror(input logic [63:0] v, input int n);
    return (v >> n) | (v << (64 - n));
  endfunction

  // Reference permutation: constant addition, 64 table S-box columns, linear layer
  function automatic logic [319:0] perm_ref(input logic [319:0] st, input int r);
    logic [63:0] a [5];
    logic [4:0] v, o;
    int j;
    for (int i = 0; i < 5; i++) a[i] = st[319-64*i -: 64];
    for (int rr = 0; rr < r; rr++) begin
      j = 12 - r + rr;
      a[2] = a[2] ^ 64'(((15 - j) << 4) | j);
      for (int b = 0; b < 64; b++) begin
        v = {a[0][b], a[1][b], a[2][b], a[3][b], a[4][b]};
        o = SBOX[v];
        a[0][b] = o[4]; a[1][b] = o[3]; a[2][b] = o[2]; a[3][b] = o[1]; a[4][b] = o[0];
      end
      a[0] = a[0] ^ ror(a[0], 19) ^ ror(a[0], 28);
      a[1] = a[1] ^ ror(a[1], 61) ^ ror(a[1], 39);
      a[2] = a[2] ^ ror(a[2], 1)  ^ ror(a[2], 6);
      a[3] = a[3] ^ ror(a[3], 10) ^ ror(a[3], 17);
      a[4] = a[4] ^ ror(a[4], 7)  ^ ror(a[4], 41);
    end
    return {a[0], a[1], a[2], a[3], a[4]};
  endfunction

  function automatic logic [319:0] rand320();
    logic [319:0] v;
    for (int i = 0; i < 10; i++) v[32*i +: 32] = $urandom;
    return v;
  endfunction

  task automatic chk(input string name, input logic [319:0] act, input logic [319:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  always begin
    @(posedge clk);
    #1;
    out_ready = bp_out ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Monitor: collects unloaded beats, pops the scoreboard, checks hold-while-stalled
  initial begin
    logic [63:0] acc [5];
    int nb;
    bit stalled;
    logic [5*W-1:0] prev;
    nb = 0;
    stalled = 1'b0;
    prev = '0;
    for (int i = 0; i < 5; i++) acc[i] = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        nb = 0;
        stalled = 1'b0;
        continue;
      end
      chk("ready_valid_exclusive", 320'(in_ready && out_valid), 320'(0));
      if (stalled && out_valid) chk("out_data_hold", 320'(out_data), 320'(prev));
      if (out_valid && out_ready) begin
        for (int i = 0; i < 5; i++) acc[i] = 64'({acc[i], out_data[(4-i)*W +: W]});
        nb++;
        if (nb == B) begin
          nb = 0;
          if (exp_q.size() == 0) chk("unexpected_output", {acc[0], acc[1], acc[2], acc[3], acc[4]}, 320'(0));
          else chk("perm_result", {acc[0], acc[1], acc[2], acc[3], acc[4]}, exp_q.pop_front());
        end
      end
      stalled = out_valid && !out_ready;
      prev = out_data;
    end
  end

  task automatic run_txn(input logic [319:0] st, input int r, input bit bp, input bit abort, input bit poke);
    int reff, nb, guard, lat, c0;
    bit acc;
    logic [63:0] lane [5];
    reff = (r > 12) ? 12 : r;
    for (int i = 0; i < 5; i++) lane[i] = st[319-64*i -: 64];
    if (!abort) exp_q.push_back(perm_ref(st, reff));
    bp_out = bp;
    start = 1'b1;
    rounds = 4'(r);
    @(posedge clk); #1;
    start = 1'b0;
    c0 = cyc;
    chk("load_entry", 320'({in_ready, busy}), 320'(2'b11));
    nb = 0;
    guard = 0;
    while (nb < B && guard < 10 * B) begin
      in_valid = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      for (int i = 0; i < 5; i++) in_data[(4-i)*W +: W] = lane[i][63 - nb*W -: W];
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      if (acc) nb++;
      guard++;
    end
    in_valid = 1'b0;
    chk("load_beats", 320'(nb), 320'(B));
    if (abort) begin
      // land in the middle of the third round's S-box pass
      repeat (2 * (B + 1) + B / 2) @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      chk("abort_idle", 320'({busy, in_ready, out_valid, out_data}), 320'(0));
      @(posedge clk); #1;
      rst = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      chk("abort_stays_idle", 320'({busy, out_valid}), 320'(0));
      return;
    end
    lat = 0;
    while (!out_valid && lat < 2000) begin
      start = poke && (lat == 3);
      if (poke) rounds = 4'd0;
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0;
    chk("latency", 320'(lat), 320'(reff * (B + 1)));
    guard = 0;
    while (busy && guard < 4000) begin
      @(posedge clk); #1;
      guard++;
    end
    chk("return_idle", 320'(busy), 320'(0));
    if (!bp) chk("total_cycles", 320'(cyc - c0 + 1), 320'(1 + B + reff * (B + 1) + B));
  endtask

  initial begin
    logic [319:0] init_st, rot_st, st;
    logic [63:0] base, l;
    init_st = {64'h80400c0600000000, 64'h0001020304050607, 64'h08090a0b0c0d0e0f,
               64'h0001020304050607, 64'h08090a0b0c0d0e0f};
    base = 64'h0123456789abcdef;
    for (int i = 0; i < 5; i++) begin
      l = (base << (8 * i)) | (base >> (64 - 8 * i));
      if (i == 0) l = base;
      rot_st[319-64*i -: 64] = l;
    end

    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", 320'({in_ready, out_valid, busy, out_data}), 320'(0));
    rst = 1'b1;
    @(posedge clk); #1;
    chk("after_reset_outputs", 320'({in_ready, out_valid, busy, out_data}), 320'(0));

    run_txn(init_st, 12, 1'b0, 1'b0, 1'b0);
    run_txn(init_st, 12, 1'b1, 1'b0, 1'b0);
    run_txn(rot_st, 0, 1'b0, 1'b0, 1'b0);
    run_txn(rand320(), 6, 1'b0, 1'b0, 1'b0);
    run_txn(rand320(), 15, 1'b0, 1'b0, 1'b0);
    run_txn(rand320(), 12, 1'b0, 1'b1, 1'b0);
    run_txn(rand320(), 12, 1'b0, 1'b0, 1'b0);
    run_txn(rand320(), 8, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 6; k++) begin
      st = rand320();
      run_txn(st, int'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'b0, 1'b0);
    end

    bp_out = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("scoreboard_drained", 320'(exp_q.size()), 320'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
